// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types: read-return tag encoding and arbiter defaults
package mips_pkg;

    typedef enum logic {
        RET_PIPE = 1'b0,
        RET_DBG  = 1'b1
    } ret_tag_e;

    localparam int STARVE_MAX_DEFAULT = 4;

    // Width needed to hold 0..max inclusive; never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - pipeline, debug and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          pipe_req;
    logic          pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata;
    logic          pipe_stall;
    logic [DW-1:0] pipe_rdata;
    logic          pipe_rvalid;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters plus the memory's read port.
    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata,
        input  pipe_stall, pipe_rdata, pipe_rvalid,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // The arbiter itself.
    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
        output pipe_stall, pipe_rdata, pipe_rvalid,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of consecutive cycles the debug port lost arbitration
module starve_counter
    import mips_pkg::*;
#(
    parameter int  MAX = STARVE_MAX_DEFAULT,
    localparam int W   = cnt_width(MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // Clear wins over increment; the count holds at MAX instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates MEM-stage and debug accesses onto one synchronous data memory
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    logic          at_max;
    logic          pipe_win;
    logic          dbg_win;
    logic          rd_issue;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    ret_tag_e      tag;
    logic          rd_pending;

    // Pipe has priority unless debug has already lost STARVE_MAX cycles in a row.
    always_comb begin
        dbg_win  = !reset && bus.dbg_req && (!bus.pipe_req || at_max);
        pipe_win = !reset && bus.pipe_req && !dbg_win;
    end

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .clear  (dbg_win || !bus.dbg_req),
        .inc    (bus.dbg_req && pipe_win),
        .at_max (at_max)
    );

    always_comb begin
        win_addr  = dbg_win ? bus.dbg_addr  : bus.pipe_addr;
        win_wdata = dbg_win ? bus.dbg_wdata : bus.pipe_wdata;
    end

    assign bus.mem_en     = pipe_win || dbg_win;
    assign bus.mem_we     = dbg_win ? bus.dbg_we : (pipe_win && bus.pipe_we);
    assign bus.mem_addr   = win_addr;
    assign bus.mem_wdata  = win_wdata;
    assign bus.pipe_stall = bus.pipe_req && !pipe_win;
    assign bus.dbg_gnt    = dbg_win;

    assign rd_issue = bus.mem_en && !bus.mem_we;

    // Remembers who owns the read in flight; memory answers exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag        <= RET_PIPE;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
            case (tag)
                RET_PIPE: if (rd_issue && dbg_win)  tag <= RET_DBG;
                RET_DBG:  if (rd_issue && pipe_win) tag <= RET_PIPE;
                default:  tag <= RET_PIPE;
            endcase
        end
    end

    // Gating with reset drops a return whose grant preceded a reset cycle.
    assign bus.pipe_rvalid = rd_pending && (tag == RET_PIPE) && !reset;
    assign bus.dbg_rvalid  = rd_pending && (tag == RET_DBG)  && !reset;
    assign bus.pipe_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[3:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.pipe_rvalid || bus.dbg_rvalid) begin
            check("rvalid_overlap", {63'd0, bus.pipe_rvalid && bus.dbg_rvalid}, 64'd0);
            check("rdata_steer", {32'd0, bus.dbg_rdata}, {32'd0, bus.pipe_rdata});
            check("rvalid_expected", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("rvalid_port", {63'd0, bus.dbg_rvalid}, {63'd0, e.port});
                check("rdata", {32'd0, bus.pipe_rdata}, {32'd0, e.data});
            end
        end
    end

    task automatic cyc(input logic preq, input logic pwe, input logic [31:0] paddr, input logic [31:0] pwd,
                       input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                       input logic exp_p, input logic exp_d, input string tag);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.pipe_req   = preq;
        bus.pipe_we    = pwe;
        bus.pipe_addr  = paddr;
        bus.pipe_wdata = pwd;
        bus.dbg_req    = dreq;
        bus.dbg_we     = dwe;
        bus.dbg_addr   = daddr;
        bus.dbg_wdata  = dwd;
        @(negedge clk);
        check({tag, "_gnt"},   {63'd0, bus.dbg_gnt},    {63'd0, exp_d});
        check({tag, "_stall"}, {63'd0, bus.pipe_stall}, {63'd0, preq && !exp_p});
        check({tag, "_en"},    {63'd0, bus.mem_en},     {63'd0, exp_p || exp_d});
        if (exp_d) begin
            check({tag, "_addr"}, {32'd0, bus.mem_addr}, {32'd0, daddr});
            check({tag, "_we"},   {63'd0, bus.mem_we},   {63'd0, dwe});
            if (dwe) begin
                check({tag, "_wdata"}, {32'd0, bus.mem_wdata}, {32'd0, dwd});
                ref_mem[daddr[3:0]] = dwd;
            end else begin
                q.push_back('{1'b1, ref_mem[daddr[3:0]]});
            end
        end else if (exp_p) begin
            check({tag, "_addr"}, {32'd0, bus.mem_addr}, {32'd0, paddr});
            check({tag, "_we"},   {63'd0, bus.mem_we},   {63'd0, pwe});
            if (pwe) begin
                check({tag, "_wdata"}, {32'd0, bus.mem_wdata}, {32'd0, pwd});
                ref_mem[paddr[3:0]] = pwd;
            end else begin
                q.push_back('{1'b0, ref_mem[paddr[3:0]]});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},     {63'd0, bus.mem_en},      64'd0);
        check({tag, "_we"},     {63'd0, bus.mem_we},      64'd0);
        check({tag, "_gnt"},    {63'd0, bus.dbg_gnt},     64'd0);
        check({tag, "_stall"},  {63'd0, bus.pipe_stall},  64'd1);
        check({tag, "_prv"},    {63'd0, bus.pipe_rvalid}, 64'd0);
        check({tag, "_drv"},    {63'd0, bus.dbg_rvalid},  64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'(i * 10);
            ref_mem[i] = 32'(i * 10);
        end
        bus.mem_rdata  = '0;
        bus.pipe_req   = 1'b1;
        bus.pipe_we    = 1'b0;
        bus.pipe_addr  = 32'd1;
        bus.pipe_wdata = '0;
        bus.dbg_req    = 1'b1;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = 32'd3;
        bus.dbg_wdata  = '0;

        // Both requesting while in reset: nothing may be granted.
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("in_reset");
        end

        // Pipe read straight out of reset, then write, then read-after-write.
        cyc(1, 0, 32'd1, 32'd0,    0, 0, 32'd0, 32'd0,  1, 0, "pipe_rd1");
        cyc(1, 1, 32'd4, 32'h5A,   0, 0, 32'd0, 32'd0,  1, 0, "pipe_wr4");
        cyc(1, 0, 32'd4, 32'd0,    0, 0, 32'd0, 32'd0,  1, 0, "pipe_rd4");
        check("after_wr_no_drv", {63'd0, bus.dbg_rvalid}, 64'd0);
        cyc(0, 0, 32'd0, 32'd0,    1, 1, 32'd5, 32'h33, 0, 1, "dbg_wr5");
        cyc(0, 0, 32'd0, 32'd0,    1, 0, 32'd5, 32'd0,  0, 1, "dbg_rd5");
        cyc(0, 0, 32'd0, 32'd0,    0, 0, 32'd0, 32'd0,  0, 0, "idle");

        // Alternating owners, back to back.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) cyc(1, 0, 32'd2, 32'd0, 0, 0, 32'd0, 32'd0, 1, 0, "alt_pipe");
            else            cyc(0, 0, 32'd0, 32'd0, 1, 0, 32'd3, 32'd0, 0, 1, "alt_dbg");
        end
        cyc(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, "idle");

        // Sustained contention: debug forced through on the 5th and 10th cycles.
        for (int i = 1; i <= 10; i++)
            cyc(1, 0, 32'd2, 32'd0, 1, 0, 32'd3, 32'd0, !(i == 5 || i == 10), (i == 5 || i == 10), "starve");
        cyc(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, "idle");

        // Dropping dbg_req restarts the starvation count.
        cyc(1, 0, 32'd2, 32'd0, 1, 0, 32'd3, 32'd0, 1, 0, "drop_lost");
        cyc(1, 0, 32'd2, 32'd0, 1, 0, 32'd3, 32'd0, 1, 0, "drop_lost");
        cyc(1, 0, 32'd2, 32'd0, 0, 0, 32'd3, 32'd0, 1, 0, "drop_gap");
        for (int i = 1; i <= 5; i++)
            cyc(1, 0, 32'd2, 32'd0, 1, 0, 32'd3, 32'd0, i != 5, i == 5, "restart");
        cyc(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, "idle");

        // Debug read immediately followed by reset loses its return.
        @(posedge clk);
        #1;
        bus.pipe_req = 1'b0;
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 32'd3;
        @(negedge clk);
        check("rst_rd_gnt", {63'd0, bus.dbg_gnt}, 64'd1);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.pipe_req = 1'b1;
        bus.dbg_req  = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_after_rd");

        cyc(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, "idle");
        cyc(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, "idle");
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning data-memory address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning data word width in bits.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning consecutive lost cycles after which the debug port is forced a grant.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pipe_req  in  1  MEM stage requests a data-memory access this cycle.
REQ-007 pipe_we  in  1  MEM stage write enable (the M control bit); 0 = read.
REQ-008 pipe_addr  in  AW  MEM stage address; pipe_wdata  in  DW  MEM stage store data.
REQ-009 pipe_stall  out  1  MEM stage access not served this cycle; pipeline holds MEM/WB.
REQ-010 pipe_rdata  out  DW  read data to MEM stage; pipe_rvalid  out  1  pipe_rdata valid.
REQ-011 dbg_req, dbg_we  in  1 each; dbg_addr  in  AW; dbg_wdata  in  DW  debug-unit access request.
REQ-012 dbg_gnt  out  1  debug access accepted this cycle; dbg_rdata  out  DW; dbg_rvalid  out  1.
REQ-013 mem_en, mem_we  out  1 each; mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW  single-port synchronous memory, 1-cycle read latency.

Function
REQ-014 Each cycle the block SHALL select at most one winner; mem_en/mem_we/mem_addr/mem_wdata SHALL be driven combinationally from the winner, mem_en=0 when no winner.
REQ-015 Only pipe_req high: pipe wins, pipe_stall=0.
REQ-016 Only dbg_req high: dbg wins, dbg_gnt=1.
REQ-017 Both high and starve_cnt < STARVE_MAX: pipe wins, dbg_gnt=0, starve_cnt increments.
REQ-018 Both high and starve_cnt == STARVE_MAX: dbg wins, pipe_stall=1, starve_cnt clears to 0.
REQ-019 starve_cnt SHALL clear whenever dbg wins or dbg_req is low; it SHALL saturate at STARVE_MAX, never wrap.
REQ-020 pipe_stall SHALL equal pipe_req AND NOT pipe-wins; dbg_gnt SHALL equal dbg wins.
REQ-021 A debug requester SHALL hold dbg_req/addr/data stable until dbg_gnt; dropping dbg_req early is legal and cancels the request.
REQ-022 A 2-state tag FSM (RET_PIPE, RET_DBG) plus a registered rd_pending bit SHALL record the owner of a read issued in cycle N.
REQ-023 In cycle N+1 pipe_rvalid (or dbg_rvalid) SHALL be 1 for exactly one cycle matching the tag; writes SHALL produce no rvalid.
REQ-024 pipe_rdata and dbg_rdata SHALL both carry mem_rdata unmodified; only the rvalid bits are steered.
REQ-025 Back-to-back reads by alternating owners SHALL each return in order with no bubble.
REQ-026 Write from either port completes in the grant cycle; write-then-read same address on consecutive cycles SHALL return the new data (memory write-first not required of the block).

Reset
REQ-027 While reset is high: mem_en=0, mem_we=0, dbg_gnt=0, pipe_stall=pipe_req, starve_cnt=0, rd_pending=0, tag=RET_PIPE, pipe_rvalid=0, dbg_rvalid=0.
REQ-028 Reset asserted the cycle after a read grant SHALL suppress that read's rvalid.
REQ-029 First grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-030 The tag state encoding and default STARVE_MAX SHALL live in the shared MIPS package (mips_pkg).
REQ-031 Starvation counter SHALL be a sub-module named starve_counter (clear, inc, saturate, at_max).
REQ-032 All other logic SHALL be flat inside dmem_arbiter; no memory instance inside.

Verification
REQ-033 Pipe read addr 1 alone, memory holds 10 at 1 -> mem_en=1 cycle N, pipe_rvalid=1 and pipe_rdata=10 cycle N+1, pipe_stall=0.
REQ-034 Pipe write addr 1 data 10 (pipe_we=1) -> mem_we=1, mem_addr=1, mem_wdata=10, no rvalid on either port.
REQ-035 pipe_req and dbg_req both held high 10 cycles, STARVE_MAX=4 -> pipe wins cycles 1-4, dbg_gnt and pipe_stall high cycle 5, pipe wins 6-9, dbg cycle 10.
REQ-036 Alternating pipe read addr 2, dbg read addr 3 on consecutive cycles -> pipe_rvalid then dbg_rvalid on consecutive cycles with correct data, no overlap.
REQ-037 dbg read granted cycle N, reset high cycle N+1 -> dbg_rvalid stays 0, all outputs at reset values.
REQ-038 dbg_req held 2 lost cycles then dropped, then reasserted with pipe busy -> counter restarts at 0, dbg granted only after 4 further lost cycles.
